fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_inst_len.sv | 17 +
 rtl/fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: Y86 icodes, instruction field ranges and byte placement helper
package fetch_unit_pkg;
    localparam int PCLEN   = 32;
    localparam int INSTBUS = 48;
    localparam int ICODE_HI = 47, ICODE_LO = 44;
    localparam int IFUN_HI  = 43, IFUN_LO  = 40;
    localparam int RA_HI    = 39, RA_LO    = 36;
    localparam int RB_HI    = 35, RB_LO    = 32;
    localparam int IMME_HI  = 31, IMME_LO  = 0;
    localparam int DEST_HI  = 39, DEST_LO  = 8;
    typedef enum logic [3:0] {
        I_HALT, I_NOP, I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL,
        I_OPL, I_JXX, I_CALL, I_RET, I_PUSHL, I_POPL
    } icode_t;
    // Bit offset in inst_o of byte k: constants are reassembled little-endian, other bytes stay in order
    function automatic logic [5:0] byte_lane(input logic [2:0] len, input logic [2:0] k);
        return (len == 3'd6 && k >= 3'd2) ? {k - 3'd2, 3'b000} :
               (len == 3'd5) ? {k, 3'b000} : 6'd40 - {k, 3'b000};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: byte-wide instruction memory read bus
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic             mem_req;
    logic [PCLEN-1:0] mem_addr;
    logic             mem_ack;
    logic [7:0]       mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit_inst_len.sv
// inst_len: instruction length in bytes from icode, with legality flag
module inst_len
    import fetch_unit_pkg::*;
(
    input  logic [3:0] icode,
    output logic [2:0] len,
    output logic       valid
);
    // Illegal icodes report length 1 so the bad byte alone is presented
    always_comb begin
        valid = icode <= 4'hB;
        len = (icode == I_HALT || icode == I_NOP || icode == I_RET) ? 3'd1 :
              (icode == I_RRMOVL || icode == I_OPL || icode == I_PUSHL || icode == I_POPL) ? 3'd2 :
              (icode == I_JXX || icode == I_CALL) ? 3'd5 :
              (icode == I_IRMOVL || icode == I_RMMOVL || icode == I_MRMOVL) ? 3'd6 : 3'd1;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetch with decode handshake, redirect, halt and illegal-op handling
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PCLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       mem,
    output logic [INSTBUS-1:0] inst_o,
    output logic [PCLEN-1:0]   pc_o,
    output logic [PCLEN-1:0]   valP_o,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    input  logic               redirect_i,
    input  logic [PCLEN-1:0]   redirect_pc_i,
    output logic               halted_o,
    output logic               bad_inst_o
);
    localparam logic [2:0] IDLE = 3'd0, BYTE0 = 3'd1, REST = 3'd2,
                           PRESENT = 3'd3, HALTED = 3'd4, ERROR = 3'd5;

    logic [2:0]       state, idx, len_r, len_b0;
    logic [PCLEN-1:0] pc;
    logic             discard, ok_b0, ack_hit;

    assign ack_hit = mem.mem_req & mem.mem_ack;

    inst_len u_len (.icode(mem.mem_rdata[7:4]), .len(len_b0), .valid(ok_b0));

    // Fetch sequencing; a redirect overrides whatever the state machine chose this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= RESET_PC;
            inst_o       <= '0;
            pc_o         <= '0;
            valP_o       <= '0;
            inst_valid_o <= 1'b0;
            halted_o     <= 1'b0;
            bad_inst_o   <= 1'b0;
            idx          <= '0;
            len_r        <= 3'd1;
            discard      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= pc;
                    state        <= BYTE0;
                end
                BYTE0: if (ack_hit) begin
                    if (discard) begin
                        discard      <= 1'b0;
                        mem.mem_addr <= pc;
                    end else begin
                        inst_o <= {mem.mem_rdata, 40'b0};
                        len_r  <= len_b0;
                        idx    <= 3'd1;
                        if (!ok_b0 || len_b0 == 3'd1) begin
                            mem.mem_req  <= 1'b0;
                            state        <= PRESENT;
                            inst_valid_o <= 1'b1;
                            bad_inst_o   <= !ok_b0;
                            pc_o         <= pc;
                            valP_o       <= pc + 32'(len_b0);
                        end else begin
                            mem.mem_addr <= mem.mem_addr + 32'd1;
                            state        <= REST;
                        end
                    end
                end
                REST: if (ack_hit) begin
                    inst_o[byte_lane(len_r, idx) +: 8] <= mem.mem_rdata;
                    if (idx == len_r - 3'd1) begin
                        mem.mem_req  <= 1'b0;
                        state        <= PRESENT;
                        inst_valid_o <= 1'b1;
                        pc_o         <= pc;
                        valP_o       <= pc + 32'(len_r);
                    end else begin
                        mem.mem_addr <= mem.mem_addr + 32'd1;
                        idx          <= idx + 3'd1;
                    end
                end
                PRESENT: if (inst_ready_i) begin
                    inst_valid_o <= 1'b0;
                    pc           <= valP_o;
                    if (bad_inst_o) state <= ERROR;
                    else if (inst_o[ICODE_HI:ICODE_LO] == I_HALT) begin
                        state    <= HALTED;
                        halted_o <= 1'b1;
                    end else begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= valP_o;
                        state        <= BYTE0;
                    end
                end
                default: ;
            endcase
            if (redirect_i && state != ERROR) begin
                pc           <= redirect_pc_i;
                inst_valid_o <= 1'b0;
                halted_o     <= 1'b0;
                bad_inst_o   <= 1'b0;
                state        <= BYTE0;
                if (ack_hit || !mem.mem_req) begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= redirect_pc_i;
                    discard      <= 1'b0;
                end else discard <= 1'b1;
            end
        end
    end
endmodule
